// File: rtl/pong_collision_score.sv
// pong_collision_score: per-pixel collision/wall detector and score keeper.
// Gathers ball/paddle overlap and top/bottom wall contact over a frame,
// judges the frame at fsync, emits one-cycle hit/miss pulses to the ball
// block and runs the SERVE / PLAY / GAMEOVER game flow.
module pong_collision_score #(
    parameter int VRES         = 720,
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60
) (
    input  logic               pixel_clk,
    input  logic               rst,
    input  logic               fsync,
    input  logic signed [11:0] hpos,
    input  logic signed [11:0] vpos,
    input  logic               ball_active,
    input  logic               paddle1_active,
    input  logic               paddle2_active,
    output logic               hit_p1,
    output logic               hit_p2,
    output logic               miss_top,
    output logic               miss_bottom,
    output logic [3:0]         score1,
    output logic [3:0]         score2,
    output logic               serve,
    output logic               game_over,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        ST_SERVE    = 2'b00,
        ST_PLAY     = 2'b01,
        ST_GAMEOVER = 2'b10
    } state_e;

    localparam logic signed [11:0] BOTTOM_ROW = 12'(VRES - 1);
    localparam logic [3:0]         WIN        = 4'(WIN_SCORE);
    localparam logic [7:0]         LAST_SERVE = 8'(SERVE_FRAMES - 1);

    // Column position plays no part in any event; kept on the port for raster symmetry.
    logic unused_hpos;
    assign unused_hpos = ^hpos;

    // Frame accumulators
    logic h1_q, h2_q, t_q, b_q;
    logic h1_d, h2_d, t_d, b_d;

    // Game state
    state_e     state_q;
    logic [7:0] frame_cnt_q;
    logic [3:0] score1_q, score2_q;
    logic [3:0] score1_inc, score2_inc;
    logic       hit_p1_q, hit_p2_q, miss_top_q, miss_bottom_q;
    logic       serve_q, game_over_q;

    // Sticky per-frame event flags; the pixel on the fsync cycle is dropped.
    always_comb begin
        h1_d = h1_q | (ball_active & paddle1_active);
        h2_d = h2_q | (ball_active & paddle2_active);
        t_d  = t_q  | (ball_active & (vpos == 12'sd0));
        b_d  = b_q  | (ball_active & (vpos == BOTTOM_ROW));
        if (fsync) begin
            h1_d = 1'b0;
            h2_d = 1'b0;
            t_d  = 1'b0;
            b_d  = 1'b0;
        end
    end

    // Accumulator registers, cleared by reset.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            h1_q <= 1'b0;
            h2_q <= 1'b0;
            t_q  <= 1'b0;
            b_q  <= 1'b0;
        end else begin
            h1_q <= h1_d;
            h2_q <= h2_d;
            t_q  <= t_d;
            b_q  <= b_d;
        end
    end

    // Saturating score increments so a score can never pass WIN_SCORE.
    always_comb begin
        score1_inc = (score1_q < WIN) ? score1_q + 4'd1 : score1_q;
        score2_inc = (score2_q < WIN) ? score2_q + 4'd1 : score2_q;
    end

    // Game FSM: judges the finished frame at fsync, updates scores and pulses.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            state_q       <= ST_SERVE;
            frame_cnt_q   <= '0;
            score1_q      <= '0;
            score2_q      <= '0;
            hit_p1_q      <= 1'b0;
            hit_p2_q      <= 1'b0;
            miss_top_q    <= 1'b0;
            miss_bottom_q <= 1'b0;
            serve_q       <= 1'b1;
            game_over_q   <= 1'b0;
        end else begin
            hit_p1_q      <= 1'b0;
            hit_p2_q      <= 1'b0;
            miss_top_q    <= 1'b0;
            miss_bottom_q <= 1'b0;
            if (fsync) begin
                unique case (state_q)
                    ST_SERVE: begin
                        if (frame_cnt_q == LAST_SERVE) begin
                            frame_cnt_q <= '0;
                            state_q     <= ST_PLAY;
                            serve_q     <= 1'b0;
                        end else begin
                            frame_cnt_q <= frame_cnt_q + 8'd1;
                        end
                    end
                    ST_PLAY: begin
                        hit_p1_q      <= h1_q;
                        hit_p2_q      <= h2_q;
                        miss_top_q    <= t_q;
                        miss_bottom_q <= b_q;
                        if (t_q && b_q) begin
                            // Ball touched both walls in one frame: no point, re-serve.
                            state_q <= ST_SERVE;
                            serve_q <= 1'b1;
                        end else if (t_q) begin
                            score2_q <= score2_inc;
                            if (score2_inc == WIN) begin
                                state_q     <= ST_GAMEOVER;
                                game_over_q <= 1'b1;
                            end else begin
                                state_q <= ST_SERVE;
                                serve_q <= 1'b1;
                            end
                        end else if (b_q) begin
                            score1_q <= score1_inc;
                            if (score1_inc == WIN) begin
                                state_q     <= ST_GAMEOVER;
                                game_over_q <= 1'b1;
                            end else begin
                                state_q <= ST_SERVE;
                                serve_q <= 1'b1;
                            end
                        end
                    end
                    ST_GAMEOVER: begin
                        state_q <= ST_GAMEOVER;
                    end
                    default: begin
                        state_q     <= ST_SERVE;
                        frame_cnt_q <= '0;
                        serve_q     <= 1'b1;
                        game_over_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign hit_p1      = hit_p1_q;
    assign hit_p2      = hit_p2_q;
    assign miss_top    = miss_top_q;
    assign miss_bottom = miss_bottom_q;
    assign score1      = score1_q;
    assign score2      = score2_q;
    assign serve       = serve_q;
    assign game_over   = game_over_q;
    assign state       = state_q;

endmodule

// File: tb/tb_pong_collision_score.sv
// Bench for pong_collision_score: short synthetic frames (a few pixels then
// fsync), a game-rules model updated per frame, per-cycle output comparison
// and a few literal checks at key points of the game.
module tb_pong_collision_score;

    localparam int VRES         = 720;
    localparam int WIN_SCORE    = 7;
    localparam int SERVE_FRAMES = 60;

    logic               pixel_clk = 1'b0;
    logic               rst = 1'b1;
    logic               fsync = 1'b0;
    logic signed [11:0] hpos = -12'sd6;
    logic signed [11:0] vpos = '0;
    logic               ball_active = 1'b0;
    logic               paddle1_active = 1'b0;
    logic               paddle2_active = 1'b0;
    logic               hit_p1, hit_p2, miss_top, miss_bottom;
    logic [3:0]         score1, score2;
    logic               serve, game_over;
    logic [1:0]         state;

    pong_collision_score #(
        .VRES         (VRES),
        .WIN_SCORE    (WIN_SCORE),
        .SERVE_FRAMES (SERVE_FRAMES)
    ) dut (
        .pixel_clk      (pixel_clk),
        .rst            (rst),
        .fsync          (fsync),
        .hpos           (hpos),
        .vpos           (vpos),
        .ball_active    (ball_active),
        .paddle1_active (paddle1_active),
        .paddle2_active (paddle2_active),
        .hit_p1         (hit_p1),
        .hit_p2         (hit_p2),
        .miss_top       (miss_top),
        .miss_bottom    (miss_bottom),
        .score1         (score1),
        .score2         (score2),
        .serve          (serve),
        .game_over      (game_over),
        .state          (state)
    );

    always #5 pixel_clk = ~pixel_clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Game model: mode 0 = serving, 1 = playing, 2 = game over
    int m_mode = 0;
    int m_s1 = 0;
    int m_s2 = 0;
    int m_frames = 0;
    bit f_h1 = 0, f_h2 = 0, f_t = 0, f_b = 0;   // what happened in the current frame
    bit e_h1 = 0, e_h2 = 0, e_t = 0, e_b = 0;   // expected pulses this cycle

    task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
        end
    endtask

    // One pixel clock: drive inputs, take the edge, advance the model.
    task automatic cyc(input bit fs, input bit b, input bit p1, input bit p2,
                       input int v, input bit r);
        fsync          = fs;
        ball_active    = b;
        paddle1_active = p1;
        paddle2_active = p2;
        vpos           = 12'(v);
        hpos           = hpos + 12'sd1;
        rst            = r;
        @(posedge pixel_clk);
        if (r) begin
            m_mode = 0; m_s1 = 0; m_s2 = 0; m_frames = 0;
            f_h1 = 0; f_h2 = 0; f_t = 0; f_b = 0;
            e_h1 = 0; e_h2 = 0; e_t = 0; e_b = 0;
        end else begin
            e_h1 = 0; e_h2 = 0; e_t = 0; e_b = 0;
            if (fs) begin
                if (m_mode == 0) begin
                    m_frames++;
                    if (m_frames == SERVE_FRAMES) begin
                        m_mode = 1;
                        m_frames = 0;
                    end
                end else if (m_mode == 1) begin
                    e_h1 = f_h1; e_h2 = f_h2; e_t = f_t; e_b = f_b;
                    if (f_t && f_b) begin
                        m_mode = 0;
                    end else if (f_t) begin
                        m_s2++;
                        m_mode = (m_s2 == WIN_SCORE) ? 2 : 0;
                    end else if (f_b) begin
                        m_s1++;
                        m_mode = (m_s1 == WIN_SCORE) ? 2 : 0;
                    end
                end
                f_h1 = 0; f_h2 = 0; f_t = 0; f_b = 0;
            end else begin
                if (b && p1) f_h1 = 1;
                if (b && p2) f_h2 = 1;
                if (b && v == 0) f_t = 1;
                if (b && v == VRES - 1) f_b = 1;
            end
        end
        #1;
    endtask

    task automatic idle_frame();
        cyc(0, 0, 0, 0, 100, 0);
        cyc(0, 0, 0, 0, 300, 0);
        cyc(0, 0, 0, 0, 500, 0);
        cyc(1, 0, 0, 0, 0, 0);
    endtask

    task automatic serve_out(input int n);
        for (int i = 0; i < n; i++) idle_frame();
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge pixel_clk) begin
        if (chk_en) begin
            chk("hit_p1", hit_p1, 4'(e_h1));
            chk("hit_p2", hit_p2, 4'(e_h2));
            chk("miss_top", miss_top, 4'(e_t));
            chk("miss_bottom", miss_bottom, 4'(e_b));
            chk("score1", score1, 4'(m_s1));
            chk("score2", score2, 4'(m_s2));
            chk("serve", serve, 4'(m_mode == 0));
            chk("game_over", game_over, 4'(m_mode == 2));
            chk("state", state, 4'(m_mode));
        end
    end

    initial begin
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk_en = 1'b1;
        chk("rst_state", state, 4'h0);
        chk("rst_serve", serve, 4'h1);
        chk("rst_score1", score1, 4'h0);
        chk("rst_score2", score2, 4'h0);

        // Serve period; frame 10 carries activity that must be ignored.
        for (int i = 1; i <= 59; i++) begin
            if (i == 10) begin
                cyc(0, 1, 1, 0, 0, 0);
                cyc(0, 1, 0, 1, 719, 0);
                cyc(1, 0, 0, 0, 0, 0);
            end else begin
                idle_frame();
            end
        end
        chk("serve_after59", state, 4'h0);
        idle_frame();
        chk("play_after60", state, 4'h1);
        chk("serve_drop60", serve, 4'h0);

        // Five overlapping pixels with the bottom paddle -> one hit_p2 pulse.
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 1, 700, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("hit_p2_pulse", hit_p2, 4'h1);
        cyc(0, 0, 0, 0, 100, 0);
        chk("hit_p2_single", hit_p2, 4'h0);
        chk("hit_state_play", state, 4'h1);
        cyc(1, 0, 0, 0, 0, 0);

        // Rows next to the walls are not misses; the fsync-cycle pixel is dropped.
        cyc(0, 1, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 718, 0);
        cyc(1, 1, 0, 0, 0, 0);
        idle_frame();
        chk("edge_rows_play", state, 4'h1);

        // Top paddle hit and top miss in one frame.
        cyc(0, 1, 1, 0, 5, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("miss_top_pulse", miss_top, 4'h1);
        chk("hit_p1_pulse", hit_p1, 4'h1);
        chk("score2_one", score2, 4'h1);
        chk("after_miss_serve", state, 4'h0);

        // Hits during serve produce nothing.
        cyc(0, 1, 1, 0, 5, 0);
        cyc(0, 1, 0, 1, 700, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("serve_no_pulse", {2'b00, hit_p1, hit_p2}, 4'h0);
        serve_out(59);
        chk("replay", state, 4'h1);

        // Both walls in one frame.
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 719, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("both_miss", {2'b00, miss_top, miss_bottom}, 4'h3);
        chk("both_score1", score1, 4'h0);
        chk("both_score2", score2, 4'h1);
        chk("both_state", state, 4'h0);

        // Seven bottom misses take player 1 to the winning score.
        for (int r = 0; r < 7; r++) begin
            serve_out(60);
            cyc(0, 1, 0, 0, 719, 0);
            cyc(1, 0, 0, 0, 0, 0);
        end
        chk("win_score1", score1, 4'h7);
        chk("win_state", state, 4'h2);
        chk("win_game_over", game_over, 4'h1);

        // Game over is frozen.
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 1, 0, 0, 0);
            cyc(0, 1, 0, 1, 719, 0);
            cyc(1, 0, 0, 0, 0, 0);
        end
        chk("frozen_score1", score1, 4'h7);
        chk("frozen_score2", score2, 4'h1);
        chk("frozen_state", state, 4'h2);

        // Reset in the middle of a frame with the accumulators set.
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 0, 1, 719, 0);
        cyc(0, 1, 1, 0, 0, 1);
        chk("midrst_state", state, 4'h0);
        chk("midrst_serve", serve, 4'h1);
        chk("midrst_game_over", game_over, 4'h0);
        chk("midrst_score1", score1, 4'h0);
        chk("midrst_score2", score2, 4'h0);
        cyc(0, 0, 0, 0, 100, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("postrst_pulses", {hit_p1, hit_p2, miss_top, miss_bottom}, 4'h0);
        chk("postrst_state", state, 4'h0);
        cyc(0, 0, 0, 0, 100, 0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pong_collision_score.md
Name: pong_collision_score

Overview:
- Per-pixel consumer of the `active` strobes from the ball and both paddle blocks. Runs on the same `hpos`/`vpos` raster.
- Accumulates overlap and wall-contact events over each frame and evaluates them at `fsync`.
- Issues one-cycle hit/miss pulses to the ball block and maintains the two player scores.
- Runs a serve/play/game-over state machine.

Parameters:
- VRES, 720, active lines per frame; bottom row is VRES-1
- WIN_SCORE, 7, score that ends the game (1..15)
- SERVE_FRAMES, 60, frames spent in SERVE before play resumes (1..255)

Ports:
- pixel_clk  in  1  pixel clock; all logic on its rising edge
- rst  in  1  reset: synchronous, active-high
- fsync  in  1  one-cycle frame-boundary strobe, same timing as seen by the paddle blocks
- hpos  in  12 signed  current pixel column
- vpos  in  12 signed  current pixel row
- ball_active  in  1  ball covers the current pixel
- paddle1_active  in  1  top paddle covers the current pixel
- paddle2_active  in  1  bottom paddle covers the current pixel
- hit_p1  out  1  one-cycle pulse: ball touched top paddle last frame
- hit_p2  out  1  one-cycle pulse: ball touched bottom paddle last frame
- miss_top  out  1  one-cycle pulse: ball reached row 0 last frame
- miss_bottom  out  1  one-cycle pulse: ball reached row VRES-1 last frame
- score1  out  4  player 1 (top) score
- score2  out  4  player 2 (bottom) score
- serve  out  1  high while in SERVE; ball block holds the ball at centre
- game_over  out  1  high in GAMEOVER
- state  out  2  SERVE=00, PLAY=01, GAMEOVER=10

Behaviour:
- Reset:
  - All pulse outputs 0; score1 = score2 = 0.
  - state = SERVE, serve = 1, game_over = 0.
  - Frame counter 0; all accumulators 0.
- Accumulators, sticky, cleared only at fsync or reset:
  - h1 set when ball_active & paddle1_active.
  - h2 set when ball_active & paddle2_active.
  - t set when ball_active & vpos == 0.
  - b set when ball_active & vpos == VRES-1.
  - The pixel presented on the fsync cycle is discarded: accumulators are cleared that cycle, not set.
- Frame evaluation happens on the fsync cycle, using the accumulator values held before the clear.
- Pulse outputs are registered: each asserts for exactly one cycle, the cycle after fsync (latency 1).
- Pulses are emitted only when state == PLAY at fsync. In SERVE and GAMEOVER they stay 0.
- FSM:
  - SERVE:
    - frame counter increments on each fsync.
    - When the counter equals SERVE_FRAMES-1 at fsync: counter clears and state goes to PLAY.
    - serve = 1 throughout.
  - PLAY, on fsync:
    - t & b (both in one frame): no score change; go to SERVE.
    - t only: score2 + 1. b only: score1 + 1.
    - After the increment, if that score equals WIN_SCORE: go to GAMEOVER. Otherwise go to SERVE.
    - Neither t nor b: stay in PLAY.
  - GAMEOVER: holds all scores; leaves only on rst.
- Hit plus miss in the same frame: both pulses are issued, and the miss decides the state transition.
- Scores never exceed WIN_SCORE; no wrap-around.
- Scores and state update on the same edge as the pulses (cycle after fsync).
- Reset mid-frame: accumulators cleared immediately; the next fsync is evaluated in SERVE with frame counter 0.
- Negative or out-of-range hpos/vpos (blanking) are harmless; the active inputs are 0 there.

Test Plan:
- Reset, then 60 fsyncs with no activity:
  - state == 00 through fsync 59.
  - state == 01 the cycle after fsync 60; serve drops to 0 at the same time.
- In PLAY, overlap ball_active & paddle2_active for 5 pixels in one frame:
  - single hit_p2 pulse one cycle after the next fsync.
  - no scoring; state stays 01.
- In PLAY, ball_active at vpos = 0:
  - miss_top pulse after fsync; score2 0 -> 1; state = SERVE.
  - the next frame's hit inputs produce no pulses.
- In PLAY, ball_active at vpos = 0 and at vpos = 719 in the same frame:
  - both miss pulses; scores unchanged; state = SERVE.
- Drive score1 to 6, then a bottom miss:
  - score1 = 7, state = 10, game_over = 1.
  - further activity and fsyncs change nothing until rst.
- Assert rst mid-frame after the accumulators have set:
  - all outputs return to reset values on the next cycle.
  - the following fsync produces no pulses.
